rec4_packer: RTL

Producer for the 33-bit four-field record consumed by the downstream adder. It accepts a byte stream over a valid/ready handshake and assembles every group of four bytes plus a carry-in bit into one record. It presents the record on a registered valid/ready output port and flags malformed groups. It sits between the byte-oriented front end and the record-consuming arithmetic stage.

---
 rtl/rec_pkg.sv | 19 +
 rtl/rec4_packer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/rec_pkg.sv
// Shared record layout for the byte packer and the downstream adder.
// Field offsets live here so producer and consumer never disagree.
package rec_pkg;

  localparam int FIELD_W = 8;
  localparam int RW      = 4 * FIELD_W + 1;

  localparam int X_LSB   = 0;
  localparam int Y_LSB   = FIELD_W;
  localparam int Z_LSB   = 2 * FIELD_W;
  localparam int W_LSB   = 3 * FIELD_W;
  localparam int CIN_BIT = 4 * FIELD_W;

  typedef enum logic {
    COLLECT = 1'b0,
    DISCARD = 1'b1
  } state_e;

endpackage

// File: rtl/rec4_packer.sv
// Packs four accepted bytes plus a carry-in into one registered record,
// flagging groups that end early (short) or run past four beats (long).
module rec4_packer
  import rec_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FIELD_W-1:0] in_data,
  input  logic               in_last,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RW-1:0]      out_rec,
  output logic               err_short,
  output logic               err_long,
  output logic [CNT_W-1:0]   rec_count
);

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [FIELD_W-1:0] x_q, x_d;
  logic [FIELD_W-1:0] y_q, y_d;
  logic [FIELD_W-1:0] z_q, z_d;
  logic [RW-1:0]      rec_q, rec_d;
  logic               vld_q, vld_d;
  logic               es_q, es_d;
  logic               el_q, el_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc;
  logic               take;

  // Only the 4th beat needs a free output slot.
  assign in_ready = !(state_q == COLLECT && idx_q == 2'd3
                      && vld_q && !out_ready);
  assign acc  = in_valid && in_ready;
  assign take = vld_q && out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    rec_d   = rec_q;
    vld_d   = vld_q && !out_ready;
    es_d    = 1'b0;
    el_d    = 1'b0;
    cnt_d   = cnt_q + CNT_W'(take);
    unique case (state_q)
      COLLECT: begin
        if (acc) begin
          if (idx_q != 2'd3) begin
            if (in_last) begin
              es_d  = 1'b1;
              idx_d = 2'd0;
            end else begin
              idx_d = idx_q + 2'd1;
              unique case (idx_q)
                2'd0:    x_d = in_data;
                2'd1:    y_d = in_data;
                default: z_d = in_data;
              endcase
            end
          end else begin
            rec_d[X_LSB +: FIELD_W] = x_q;
            rec_d[Y_LSB +: FIELD_W] = y_q;
            rec_d[Z_LSB +: FIELD_W] = z_q;
            rec_d[W_LSB +: FIELD_W] = in_data;
            rec_d[CIN_BIT]          = in_cin;
            vld_d = 1'b1;
            idx_d = 2'd0;
            if (!in_last) begin
              el_d    = 1'b1;
              state_d = DISCARD;
            end
          end
        end
      end
      DISCARD: begin
        if (acc && in_last) begin
          state_d = COLLECT;
          idx_d   = 2'd0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= 2'd0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      rec_q   <= '0;
      vld_q   <= 1'b0;
      es_q    <= 1'b0;
      el_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      rec_q   <= rec_d;
      vld_q   <= vld_d;
      es_q    <= es_d;
      el_q    <= el_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign out_rec   = rec_q;
  assign err_short = es_q;
  assign err_long  = el_q;
  assign rec_count = cnt_q;

endmodule
